// File: rtl/ifu_pkg.sv
// ifu_pkg: shared IFU constants, FSM state encoding, cache way record and PLRU strobe bundle
package ifu_pkg;
  localparam int WAYS_NUM  = 16;
  localparam int WAY_IDX_W = $clog2(WAYS_NUM);
  localparam int ADDR_W    = 32;
  localparam int LINE_W    = 128;
  localparam int OFFSET_W  = 4;
  localparam int TAG_W     = ADDR_W - OFFSET_W;
  typedef struct packed {
    logic update_tree;
    logic update_counter;
  } t_cache_ctrl2_plru;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL_RSP} t_ifu_state;
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } t_cache_way;
endpackage

// File: rtl/ifu_tag_cmp.sv
// ifu_tag_cmp: combinational tag/valid compare across all ways (tag,valid,tags in; match one-hot, hit, binary idx out)
module ifu_tag_cmp
  import ifu_pkg::*;
(
  input  logic [TAG_W-1:0]                tag,
  input  logic [WAYS_NUM-1:0]             valid,
  input  logic [WAYS_NUM-1:0][TAG_W-1:0]  tags,
  output logic [WAYS_NUM-1:0]             match,
  output logic                            hit,
  output logic [WAY_IDX_W-1:0]            idx
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < WAYS_NUM; i++) begin
      match[i] = valid[i] && tags[i] == tag;
      idx      = idx | (match[i] ? WAY_IDX_W'(i) : '0);
    end
    hit = |match;
  end
endmodule

// File: rtl/ifu_cache_ctrl.sv
// ifu_cache_ctrl: fully associative I-cache controller (fetch req/rsp, memory line fill, PLRU strobes/victim)
module ifu_cache_ctrl
  import ifu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req_valid,
  input  logic [ADDR_W-1:0]     fetch_req_addr,
  output logic                  fetch_req_ready,
  output logic                  fetch_rsp_valid,
  output logic [31:0]           fetch_rsp_instr,
  input  logic                  flush,
  output logic                  mem_req_valid,
  output logic [ADDR_W-1:0]     mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [LINE_W-1:0]     mem_rsp_data,
  output t_cache_ctrl2_plru     cache_ctrl2_plru,
  output logic                  cache_miss,
  output logic [WAY_IDX_W-1:0]  hit_cl,
  input  logic [WAY_IDX_W-1:0]  evicted_cl
);
  t_cache_way                     ways [WAYS_NUM];
  t_ifu_state                     state;
  logic [TAG_W-1:0]               tag_q;
  logic [1:0]                     word_q;
  logic [WAY_IDX_W-1:0]           victim_q;
  logic                           flush_pend;
  logic [WAYS_NUM-1:0]            valid_v;
  logic [WAYS_NUM-1:0][TAG_W-1:0] tags_v;
  logic [WAYS_NUM-1:0]            match;
  logic                           hit;
  logic [WAY_IDX_W-1:0]           hit_idx;
  logic                           accept, flush_n, idle_n;
  logic                           unused;
  assign unused = ^fetch_req_addr[1:0];
  always_comb begin
    for (int i = 0; i < WAYS_NUM; i++) begin
      valid_v[i] = ways[i].valid;
      tags_v[i]  = ways[i].tag;
    end
  end
  // The compare runs on the incoming address at acceptance so that all
  // LOOKUP-cycle outputs can be registered; no way changes between the
  // acceptance edge and LOOKUP, so this equals comparing the latched tag.
  ifu_tag_cmp u_tag_cmp (
    .tag   (fetch_req_addr[ADDR_W-1:OFFSET_W]),
    .valid (valid_v),
    .tags  (tags_v),
    .match (match),
    .hit   (hit),
    .idx   (hit_idx)
  );
  // fetch_req_ready is registered, so it is derived from next-cycle state and flush_pend.
  always_comb begin
    accept  = state == IDLE && fetch_req_valid && fetch_req_ready;
    flush_n = flush || (flush_pend && state != IDLE);
    idle_n  = state == IDLE   ? !accept :
              state == LOOKUP ? !cache_miss : state == FILL_RSP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      flush_pend       <= 1'b0;
      fetch_req_ready  <= 1'b0;
      fetch_rsp_valid  <= 1'b0;
      fetch_rsp_instr  <= '0;
      mem_req_valid    <= 1'b0;
      mem_req_addr     <= '0;
      cache_ctrl2_plru <= '0;
      cache_miss       <= 1'b0;
      hit_cl           <= '0;
      for (int i = 0; i < WAYS_NUM; i++) ways[i].valid <= 1'b0;
    end else begin
      fetch_rsp_valid  <= 1'b0;
      cache_ctrl2_plru <= '0;
      cache_miss       <= 1'b0;
      hit_cl           <= '0;
      flush_pend       <= flush_n;
      fetch_req_ready  <= idle_n && !flush_n;
      case (state)
        IDLE: begin
          if (flush_pend) begin
            for (int i = 0; i < WAYS_NUM; i++) ways[i].valid <= 1'b0;
          end else if (accept) begin
            tag_q                           <= fetch_req_addr[ADDR_W-1:OFFSET_W];
            word_q                          <= fetch_req_addr[3:2];
            state                           <= LOOKUP;
            cache_miss                      <= !hit;
            cache_ctrl2_plru.update_tree    <= 1'b1;
            cache_ctrl2_plru.update_counter <= !hit && !(&valid_v);
            fetch_rsp_valid                 <= hit;
            hit_cl                          <= hit ? hit_idx : '0;
            if (hit) fetch_rsp_instr <= ways[hit_idx].data[{fetch_req_addr[3:2], 5'd0} +: 32];
          end
        end
        LOOKUP: begin
          if (cache_miss) begin
            victim_q      <= evicted_cl;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {tag_q, {OFFSET_W{1'b0}}};
            state         <= MISS_REQ;
          end else begin
            state <= IDLE;
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (mem_rsp_valid) begin
            ways[victim_q]  <= {1'b1, tag_q, mem_rsp_data};
            fetch_rsp_valid <= 1'b1;
            fetch_rsp_instr <= mem_rsp_data[{word_q, 5'd0} +: 32];
            state           <= FILL_RSP;
          end
        end
        FILL_RSP: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
  a_match_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(match));
endmodule

// File: tb/tb_ifu_cache_ctrl.sv
// tb_ifu_cache_ctrl: table-driven fetch transactions plus hand-written reset and stray-response sequences
module tb_ifu_cache_ctrl;
  import ifu_pkg::*;
  logic              clk = 0;
  logic              rst = 1;
  logic              fetch_req_valid = 0;
  logic [31:0]       fetch_req_addr = 0;
  logic              fetch_req_ready;
  logic              fetch_rsp_valid;
  logic [31:0]       fetch_rsp_instr;
  logic              flush = 0;
  logic              mem_req_valid;
  logic [31:0]       mem_req_addr;
  logic              mem_req_ready = 0;
  logic              mem_rsp_valid = 0;
  logic [127:0]      mem_rsp_data = 0;
  t_cache_ctrl2_plru cache_ctrl2_plru;
  logic              cache_miss;
  logic [3:0]        hit_cl;
  logic [3:0]        evicted_cl = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        do_rst;
    logic [31:0] addr;
    logic [3:0]  evict;
    logic        miss;
    logic [3:0]  cl;
    logic        ctr;
    int          stall;
    logic        fl;
  } vec_t;
  vec_t tbl[$];
  ifu_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .fetch_req_valid(fetch_req_valid), .fetch_req_addr(fetch_req_addr), .fetch_req_ready(fetch_req_ready),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_instr(fetch_rsp_instr),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .cache_ctrl2_plru(cache_ctrl2_plru), .cache_miss(cache_miss), .hit_cl(hit_cl), .evicted_cl(evicted_cl)
  );
  always #5 clk = ~clk;
  // Memory model: each word encodes its own address, except the one tagged DEADBEEF word.
  function automatic logic [31:0] word_of(logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00} + 32'h5A00_0000;
    if ({a[31:2], 2'b00} == 32'h0000_1008) w = 32'hDEAD_BEEF;
    return w;
  endfunction
  function automatic logic [127:0] line_of(logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = word_of({a[31:4], 4'b0} + 32'(4 * k));
    return l;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic add(logic r, logic [31:0] a, logic [3:0] e, logic m, logic [3:0] c, logic ct, int s, logic f);
    vec_t v;
    v.do_rst = r; v.addr = a; v.evict = e; v.miss = m; v.cl = c; v.ctr = ct; v.stall = s; v.fl = f;
    tbl.push_back(v);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!fetch_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", fetch_req_ready, 1);
  endtask
  task automatic run(vec_t v);
    if (v.do_rst) do_reset();
    evicted_cl = v.evict;
    wait_ready();
    fetch_req_valid = 1;
    fetch_req_addr  = v.addr;
    @(posedge clk);
    #1 fetch_req_valid = 0;
    @(negedge clk);
    chk($sformatf("miss@%h", v.addr), cache_miss, v.miss);
    chk($sformatf("tree@%h", v.addr), cache_ctrl2_plru.update_tree, 1);
    chk($sformatf("ctr@%h", v.addr), cache_ctrl2_plru.update_counter, v.miss ? v.ctr : 1'b0);
    chk($sformatf("hitcl@%h", v.addr), hit_cl, v.miss ? 4'd0 : v.cl);
    chk($sformatf("rspv_lookup@%h", v.addr), fetch_rsp_valid, !v.miss);
    chk($sformatf("ready_lookup@%h", v.addr), fetch_req_ready, 0);
    if (!v.miss) chk($sformatf("hit_instr@%h", v.addr), fetch_rsp_instr, word_of(v.addr));
    if (v.miss) begin
      @(negedge clk);
      chk($sformatf("mreq_v@%h", v.addr), mem_req_valid, 1);
      chk($sformatf("mreq_a@%h", v.addr), mem_req_addr, {v.addr[31:4], 4'b0});
      chk($sformatf("plru_mreq@%h", v.addr), cache_ctrl2_plru, 0);
      for (int s = 0; s < v.stall; s++) begin
        @(negedge clk);
        chk($sformatf("stall_v@%h", v.addr), mem_req_valid, 1);
        chk($sformatf("stall_a@%h", v.addr), mem_req_addr, {v.addr[31:4], 4'b0});
        chk($sformatf("stall_rdy@%h", v.addr), fetch_req_ready, 0);
        chk($sformatf("stall_rsp@%h", v.addr), fetch_rsp_valid, 0);
      end
      mem_req_ready = 1;
      @(posedge clk);
      #1 mem_req_ready = 0;
      @(negedge clk);
      chk($sformatf("mreq_drop@%h", v.addr), mem_req_valid, 0);
      if (v.fl) begin
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        @(negedge clk);
      end
      mem_rsp_valid = 1;
      mem_rsp_data  = line_of(v.addr);
      @(posedge clk);
      #1 mem_rsp_valid = 0;
      @(negedge clk);
      chk($sformatf("fill_rspv@%h", v.addr), fetch_rsp_valid, 1);
      chk($sformatf("fill_instr@%h", v.addr), fetch_rsp_instr, word_of(v.addr));
      chk($sformatf("plru_fill@%h", v.addr), cache_ctrl2_plru, 0);
    end
    @(negedge clk);
    chk($sformatf("rsp_pulse@%h", v.addr), fetch_rsp_valid, 0);
    chk($sformatf("no_mreq_after@%h", v.addr), mem_req_valid, 0);
  endtask
  initial begin
    add(1, 32'h0000_1008, 4'd0, 1, 4'd0, 1, 0, 0);
    add(0, 32'h0000_100C, 4'd9, 0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(i == 0, 32'(16 * i), 4'(i), 1, 4'd0, 1, 0, 0);
    add(0, 32'h0000_0100, 4'd5,  1, 4'd0,  0, 0, 0);
    add(0, 32'h0000_0054, 4'd7,  1, 4'd0,  0, 0, 0);
    add(0, 32'h0000_0104, 4'd0,  0, 4'd5,  0, 0, 0);
    add(0, 32'h0000_00A8, 4'd0,  0, 4'd10, 0, 0, 0);
    add(0, 32'h0000_0074, 4'd9,  1, 4'd0,  0, 0, 0);
    add(0, 32'h0000_009C, 4'd2,  1, 4'd0,  0, 0, 0);
    add(0, 32'h0000_0024, 4'd11, 1, 4'd0,  0, 0, 0);
    add(0, 32'h0000_0400, 4'd3,  1, 4'd0,  0, 0, 1);
    add(0, 32'h0000_0400, 4'd0,  1, 4'd0,  1, 0, 0);
    add(0, 32'h0000_0404, 4'd6,  0, 4'd0,  0, 0, 0);
    add(0, 32'h0000_0800, 4'd1,  1, 4'd0,  1, 5, 0);
    add(0, 32'h0000_0808, 4'd6,  0, 4'd1,  0, 0, 0);
    @(negedge clk);
    chk("rst_ready", fetch_req_ready, 0);
    chk("rst_rspv", fetch_rsp_valid, 0);
    chk("rst_instr", fetch_rsp_instr, 0);
    chk("rst_mreqv", mem_req_valid, 0);
    chk("rst_mreqa", mem_req_addr, 0);
    chk("rst_plru", cache_ctrl2_plru, 0);
    chk("rst_miss", cache_miss, 0);
    chk("rst_hitcl", hit_cl, 0);
    foreach (tbl[i]) run(tbl[i]);
    evicted_cl = 4'd4;
    wait_ready();
    fetch_req_valid = 1;
    fetch_req_addr  = 32'h0000_3000;
    @(posedge clk);
    #1 fetch_req_valid = 0;
    @(negedge clk);
    chk("mid_lookup_miss", cache_miss, 1);
    @(negedge clk);
    chk("mid_mreq_v", mem_req_valid, 1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("mid_rst_mreqv", mem_req_valid, 0);
    chk("mid_rst_mreqa", mem_req_addr, 0);
    chk("mid_rst_ready", fetch_req_ready, 0);
    chk("mid_rst_rspv", fetch_rsp_valid, 0);
    chk("mid_rst_instr", fetch_rsp_instr, 0);
    chk("mid_rst_plru", cache_ctrl2_plru, 0);
    chk("mid_rst_miss", cache_miss, 0);
    chk("mid_rst_hitcl", hit_cl, 0);
    mem_rsp_valid = 1;
    mem_rsp_data  = line_of(32'h0000_3000);
    @(posedge clk);
    #1 mem_rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_rsp", fetch_rsp_valid, 0);
      chk("stray_mreq", mem_req_valid, 0);
    end
    begin
      vec_t v;
      v.do_rst = 0; v.addr = 32'h0000_080C; v.evict = 4'd0; v.miss = 1; v.cl = 0; v.ctr = 1; v.stall = 0; v.fl = 0;
      run(v);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ifu_cache_ctrl.md
Name: ifu_cache_ctrl

Overview:
Fully associative 16-way instruction cache controller for the IFU, placed directly upstream of the PLRU replacement block.
- Accepts fetch requests from the fetch stage and performs the tag lookup.
- Returns hits from its internal line storage.
- On a miss, fetches the line from memory and fills the victim way supplied by the PLRU.
- Drives the PLRU interface: cache_ctrl2_plru, cache_miss, hit_cl. Consumes evicted_cl.

Parameters:
WAYS_NUM, 16, number of ways (ifu_pkg constant; the PLRU uses the same value)
LINE_W, 128, cache line width in bits (4 instructions)
ADDR_W, 32, fetch address width
TAG_W, 28, tag width = address bits [31:4]

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_req_valid  in  1  fetch request valid
fetch_req_addr  in  32  fetch PC; bits [1:0] ignored
fetch_req_ready  out  1  controller can accept a request
fetch_rsp_valid  out  1  instruction valid, one-cycle pulse
fetch_rsp_instr  out  32  returned instruction
flush  in  1  invalidate all ways
mem_req_valid  out  1  line fill request
mem_req_addr  out  32  line-aligned address, [3:0]=0
mem_req_ready  in  1  memory accepts the request
mem_rsp_valid  in  1  fill data valid
mem_rsp_data  in  128  fill line; word k is bits [32k+31:32k]
cache_ctrl2_plru  out  t_cache_ctrl2_plru  update_tree / update_counter strobes
cache_miss  out  1  lookup missed
hit_cl  out  4  way that hit
evicted_cl  in  4  PLRU victim way, valid in the same cycle as cache_miss

Behaviour:
- Storage: per way a valid bit, TAG_W tag and LINE_W data, all in flops. Only the valid bits are reset.
- Reset values: fetch_req_ready=0, fetch_rsp_valid=0, fetch_rsp_instr=0, mem_req_valid=0, mem_req_addr=0, cache_ctrl2_plru=0, cache_miss=0, hit_cl=0, all valid=0, state=IDLE, flush_pend=0.
- Reset mid-miss aborts the fill. mem_req_valid is 0 the cycle after rst. A later stray mem_rsp_valid is ignored in IDLE.
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL_RSP.
- IDLE:
  - fetch_req_ready=1 only when flush_pend=0.
  - If flush_pend=1: clear all valid bits and flush_pend, stay in IDLE.
  - Else if fetch_req_valid: latch the address, go to LOOKUP.
- LOOKUP (cycle N+1 after acceptance):
  - Compare the latched tag against all valid ways.
  - Hit:
    - fetch_rsp_valid=1; instr = word addr[3:2] of the hit way.
    - hit_cl = hit way index; cache_miss=0; update_tree=1 for one cycle.
    - Go to IDLE. Hit latency is 1 cycle after acceptance.
  - Miss:
    - cache_miss=1; update_tree=1; latch evicted_cl into victim_q.
    - update_counter=1 only if not all ways are valid.
    - Go to MISS_REQ.
  - Multiple matching ways cannot occur by construction. An SVA asserts one-hot or zero matches.
- MISS_REQ:
  - mem_req_valid=1, mem_req_addr = {tag,4'b0}.
  - Valid and address are held stable until mem_req_ready. The handshake cycle moves to MISS_WAIT.
- MISS_WAIT:
  - On mem_rsp_valid, write tag, data and valid=1 into victim_q, then go to FILL_RSP.
  - One outstanding request only. mem_rsp_valid in any other state is ignored.
- FILL_RSP:
  - fetch_rsp_valid=1 with the word from the registered fill line.
  - Go to IDLE. No PLRU strobes.
- Flush:
  - flush in any cycle sets flush_pend; it executes in IDLE before any new request.
  - A flush during a miss lets the fill complete and respond, then invalidates.
  - The PLRU tree and counter are not reset by flush.
- PLRU strobes are never asserted outside LOOKUP. hit_cl holds 0 when there is no hit.
- fetch_req_ready=0 in every non-IDLE state; throughput is at most 1 request per 2 cycles.

Decomposition:
- ifu_pkg additions: TAG_W, LINE_W, OFFSET_W=4, the t_ifu_state enum and t_cache_way struct {valid, tag, data}.
- t_cache_ctrl2_plru and WAYS_NUM remain in ifu_pkg.
- One sub-module: ifu_tag_cmp. It is combinational: WAYS_NUM tag/valid compare, producing a hit flag and a one-hot-to-binary way index.

Test Plan:
- Cold miss: after rst, request 0x0000_1008 → cache_miss=1, update_tree=1, update_counter=1 in LOOKUP; mem_req_addr=0x0000_1000; mem_rsp_data word2=0xDEADBEEF → fetch_rsp_instr=0xDEADBEEF in FILL_RSP; way 0 valid.
- Hit: then request 0x0000_100C → fetch_rsp_valid one cycle after acceptance, instr=word3, hit_cl=0, update_tree=1, no mem_req.
- Fill all: 16 distinct lines 0x0,0x10,…,0xF0 → ways 0..15 filled in order. On the 17th miss (0x100) update_counter=0, the line is written to the evicted_cl value, and the displaced line misses on re-access.
- Backpressure: hold mem_req_ready=0 for 5 cycles → mem_req_valid/addr stable; fetch_req_ready=0 throughout; exactly one response.
- Flush mid-miss: assert flush in MISS_WAIT → fill response still returned; next request to the same line misses.
- Reset mid-miss: rst in MISS_REQ → mem_req_valid=0 the next cycle, all outputs at reset values, a previously cached address misses.
